// File: rtl/gol_engine.sv
// gol_engine: Game-of-Life core with row-serial generation stepping.
// The board loads row by row from active-low buttons. Each generation is
// computed one row per cycle into a shadow board, then committed in one cycle.
// Optional macro GOL_TORUS_EN: edges wrap toroidally instead of reading dead.
//
// state  | meaning
// IDLE   | accept load edges, or start a generation on run edge / free_run
// STEP   | compute next[row_idx] from the committed board, one row per cycle
// COMMIT | copy next into board, update generation and stable
module gol_engine #(
  parameter int HEIGHT = 5,
  parameter int WIDTH  = 5,
  parameter int GEN_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset_btn,
  input  logic                          load_btn,
  input  logic                          run_btn,
  input  logic                          free_run,
  input  logic [WIDTH-1:0]              data_in,
  input  logic [8:0]                    birth_mask,
  input  logic [8:0]                    survive_mask,
  output logic [0:HEIGHT-1][0:WIDTH-1]  board,
  output logic [GEN_W-1:0]              generation,
  output logic                          busy,
  output logic                          stable
);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, STEP, COMMIT} state_t;

  state_t                       state_q, state_d;
  logic [0:HEIGHT-1][0:WIDTH-1] board_q, board_d;
  logic [0:HEIGHT-1][0:WIDTH-1] next_q, next_d;
  logic [GEN_W-1:0]             gen_q, gen_d;
  logic                         busy_q, busy_d;
  logic                         stable_q, stable_d;
  logic [RW-1:0]                load_row_q, load_row_d;
  logic [RW-1:0]                row_idx_q, row_idx_d;
  logic [8:0]                   birth_q, birth_d;
  logic [8:0]                   surv_q, surv_d;
  logic                         load_sync_q, run_sync_q;

  logic                         load_edge, run_edge;
  logic [0:WIDTH-1]             row_up, row_mid, row_dn, row_new;
  logic [3:0]                   cnt;
  int                           col;

  assign load_edge  = load_sync_q & ~load_btn;
  assign run_edge   = run_sync_q & ~run_btn;
  assign board      = board_q;
  assign generation = gen_q;
  assign busy       = busy_q;
  assign stable     = stable_q;

  // Fetch the row being computed and its two vertical neighbours.
  always_comb begin
    row_mid = board_q[row_idx_q];
`ifdef GOL_TORUS_EN
    row_up = (row_idx_q == '0) ? board_q[HEIGHT-1] : board_q[row_idx_q - 1'b1];
    row_dn = (row_idx_q == LAST_ROW) ? board_q[0] : board_q[row_idx_q + 1'b1];
`else
    row_up = (row_idx_q == '0) ? '0 : board_q[row_idx_q - 1'b1];
    row_dn = (row_idx_q == LAST_ROW) ? '0 : board_q[row_idx_q + 1'b1];
`endif
  end

  // Neighbour count and rule lookup for every cell of the current row.
  always_comb begin
    row_new = '0;
    cnt     = '0;
    col     = 0;
    for (int c = 0; c < WIDTH; c++) begin
      cnt = '0;
      for (int dc = -1; dc <= 1; dc++) begin
        col = c + dc;
`ifdef GOL_TORUS_EN
        if (col < 0) col = WIDTH - 1;
        else if (col >= WIDTH) col = 0;
`endif
        if (col >= 0 && col < WIDTH) begin
          cnt = cnt + {3'b000, row_up[col[CW-1:0]]} + {3'b000, row_dn[col[CW-1:0]]};
          if (dc != 0) cnt = cnt + {3'b000, row_mid[col[CW-1:0]]};
        end
      end
      row_new[c] = row_mid[c] ? surv_q[cnt] : birth_q[cnt];
    end
  end

  // Next-state logic for the sequencer and all board state.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    next_d     = next_q;
    gen_d      = gen_q;
    busy_d     = busy_q;
    stable_d   = stable_q;
    load_row_d = load_row_q;
    row_idx_d  = row_idx_q;
    birth_d    = birth_q;
    surv_d     = surv_q;
    case (state_q)
      IDLE: begin
        if (load_edge) begin
          for (int c = 0; c < WIDTH; c++) board_d[load_row_q][c] = data_in[c];
          load_row_d = (load_row_q == LAST_ROW) ? '0 : load_row_q + 1'b1;
          gen_d      = '0;
          stable_d   = 1'b0;
        end else if (run_edge || free_run) begin
          birth_d   = birth_mask;
          surv_d    = survive_mask;
          row_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = STEP;
        end
      end
      STEP: begin
        next_d[row_idx_q] = row_new;
        if (row_idx_q == LAST_ROW) state_d = COMMIT;
        else row_idx_d = row_idx_q + 1'b1;
      end
      COMMIT: begin
        board_d  = next_q;
        stable_d = (next_q == board_q);
        gen_d    = gen_q + 1'b1;
        if (free_run) begin
          birth_d   = birth_mask;
          surv_d    = survive_mask;
          row_idx_d = '0;
          state_d   = STEP;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any partially computed generation.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      state_q     <= IDLE;
      board_q     <= '0;
      next_q      <= '0;
      gen_q       <= '0;
      busy_q      <= 1'b0;
      stable_q    <= 1'b0;
      load_row_q  <= '0;
      row_idx_q   <= '0;
      birth_q     <= '0;
      surv_q      <= '0;
      load_sync_q <= 1'b1;
      run_sync_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      next_q      <= next_d;
      gen_q       <= gen_d;
      busy_q      <= busy_d;
      stable_q    <= stable_d;
      load_row_q  <= load_row_d;
      row_idx_q   <= row_idx_d;
      birth_q     <= birth_d;
      surv_q      <= surv_d;
      load_sync_q <= load_btn;
      run_sync_q  <= run_btn;
    end
  end

endmodule

// File: tb/tb_gol_engine.sv
// Directed testbench for gol_engine (5x5 board, Conway and HighLife rules).
module tb_gol_engine;
  typedef logic [0:4][0:4] brd_t;

  logic        clk = 1'b0;
  logic        reset_btn, load_btn, run_btn, free_run;
  logic [4:0]  data_in;
  logic [8:0]  birth_mask, survive_mask;
  brd_t        board;
  logic [15:0] generation;
  logic        busy, stable;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [8:0] CONWAY_B = 9'h008;
  localparam logic [8:0] CONWAY_S = 9'h00C;
  localparam logic [8:0] HLIFE_B  = 9'h048;
  localparam logic [8:0] HLIFE_S  = 9'h00C;

  gol_engine #(.HEIGHT(5), .WIDTH(5), .GEN_W(16)) dut (
    .clk          (clk),
    .reset_btn    (reset_btn),
    .load_btn     (load_btn),
    .run_btn      (run_btn),
    .free_run     (free_run),
    .data_in      (data_in),
    .birth_mask   (birth_mask),
    .survive_mask (survive_mask),
    .board        (board),
    .generation   (generation),
    .busy         (busy),
    .stable       (stable)
  );

  always #5 clk = ~clk;

  // Row values use bit c = column c, same as data_in.
  function automatic brd_t mk(input logic [4:0] r0, r1, r2, r3, r4);
    brd_t b;
    for (int c = 0; c < 5; c++) begin
      b[0][c] = r0[c]; b[1][c] = r1[c]; b[2][c] = r2[c];
      b[3][c] = r3[c]; b[4][c] = r4[c];
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press_load(input logic [4:0] d);
    data_in  = d;
    load_btn = 1'b0;
    tick();
    load_btn = 1'b1;
    tick();
  endtask

  task automatic load5(input logic [4:0] r0, r1, r2, r3, r4);
    press_load(r0); press_load(r1); press_load(r2); press_load(r3); press_load(r4);
  endtask

  task automatic run_gen();
    run_btn = 1'b0;
    tick();
    run_btn = 1'b1;
    repeat (6) tick();
  endtask

  brd_t horiz, vert, blk, exp_b;

  initial begin
    horiz = mk(5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000);
    vert  = mk(5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000);
    blk   = mk(5'b00000, 5'b00110, 5'b00110, 5'b00000, 5'b00000);

    reset_btn    = 1'b0;
    load_btn     = 1'b1;
    run_btn      = 1'b1;
    free_run     = 1'b0;
    data_in      = '0;
    birth_mask   = CONWAY_B;
    survive_mask = CONWAY_S;
    repeat (3) tick();
    check("reset_board", 64'(board), 64'(brd_t'('0)));
    check("reset_gen", 64'(generation), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stable", 64'(stable), 64'd0);
    reset_btn = 1'b1;
    tick();

    // Blinker: load latency checked on row 2
    press_load(5'b00000);
    press_load(5'b00000);
    data_in  = 5'b01110;
    load_btn = 1'b0;
    tick();
    check("load_latency", 64'(board), 64'(horiz));
    load_btn = 1'b1;
    tick();
    press_load(5'b00000);
    press_load(5'b00000);
    check("blinker_loaded", 64'(board), 64'(horiz));

    run_btn = 1'b0;
    tick();
    check("busy_after_edge", 64'(busy), 64'd1);
    run_btn = 1'b1;
    repeat (5) tick();
    check("busy_before_commit", 64'(busy), 64'd1);
    check("board_held_mid_step", 64'(board), 64'(horiz));
    tick();
    check("blinker_gen1_board", 64'(board), 64'(vert));
    check("blinker_gen1_count", 64'(generation), 64'd1);
    check("blinker_gen1_stable", 64'(stable), 64'd0);
    check("blinker_gen1_idle", 64'(busy), 64'd0);
    run_gen();
    check("blinker_gen2_board", 64'(board), 64'(horiz));
    check("blinker_gen2_count", 64'(generation), 64'd2);

    // Still life
    load5(5'b00000, 5'b00110, 5'b00110, 5'b00000, 5'b00000);
    check("block_load_gen_clear", 64'(generation), 64'd0);
    run_gen();
    check("block_board", 64'(board), 64'(blk));
    check("block_stable", 64'(stable), 64'd1);
    check("block_gen", 64'(generation), 64'd1);

    // Edge behaviour
    load5(5'b01110, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    run_gen();
`ifdef GOL_TORUS_EN
    exp_b = mk(5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00100);
`else
    exp_b = mk(5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
`endif
    check("edge_row0", 64'(board), 64'(exp_b));

    // Free run for 30 cycles with button pulses while busy
    load5(5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000);
    free_run = 1'b1;
    tick();
    repeat (7) tick();
    data_in  = 5'b11111;
    load_btn = 1'b0;
    run_btn  = 1'b0;
    tick();
    load_btn = 1'b1;
    run_btn  = 1'b1;
    tick();
    check("free_run_busy", 64'(busy), 64'd1);
    check("busy_load_ignored", 64'(board), 64'(vert));
    repeat (20) tick();
    free_run = 1'b0;
    tick();
    check("free_run_gen", 64'(generation), 64'd5);
    check("free_run_board", 64'(board), 64'(vert));
    check("free_run_stopped", 64'(busy), 64'd0);
    tick();
    check("free_run_no_extra", 64'(busy), 64'd0);
    press_load(5'b11111);
    exp_b = mk(5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00000);
    check("load_row_unchanged", 64'(board), 64'(exp_b));

    // HighLife with masks flipped mid-step
    reset_btn = 1'b0;
    tick();
    reset_btn = 1'b1;
    tick();
    load5(5'b00000, 5'b01110, 5'b01010, 5'b00010, 5'b00000);
    birth_mask   = HLIFE_B;
    survive_mask = HLIFE_S;
    run_btn = 1'b0;
    tick();
    run_btn = 1'b1;
    birth_mask   = CONWAY_B;
    survive_mask = CONWAY_S;
    repeat (6) tick();
    exp_b = mk(5'b00100, 5'b01010, 5'b01111, 5'b00100, 5'b00000);
    check("highlife_board", 64'(board), 64'(exp_b));
    check("highlife_born6", 64'(board[2][2]), 64'd1);

    // Reset during STEP cycle 2
    run_btn = 1'b0;
    tick();
    run_btn = 1'b1;
    tick();
    reset_btn = 1'b0;
    #1;
    check("mid_reset_board", 64'(board), 64'(brd_t'('0)));
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_gen", 64'(generation), 64'd0);
    tick();
    reset_btn = 1'b1;
    tick();

    // Load and run edges together: load wins
    data_in  = 5'b10001;
    load_btn = 1'b0;
    run_btn  = 1'b0;
    tick();
    load_btn = 1'b1;
    run_btn  = 1'b1;
    exp_b = mk(5'b10001, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    check("load_wins_board", 64'(board), 64'(exp_b));
    check("load_wins_busy", 64'(busy), 64'd0);
    repeat (7) tick();
    check("run_discarded_busy", 64'(busy), 64'd0);
    check("run_discarded_gen", 64'(generation), 64'd0);
    check("run_discarded_board", 64'(board), 64'(exp_b));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
